// File: rtl/msg_transmitter.sv
// Packs one buffered message into 64-bit AXI-Stream beats, least-significant byte first,
// with a partial final beat, tlast on the final beat and an optional error flag in tuser.
module msg_transmitter #(
  parameter int MAX_MSG_BYTES = 32,
  parameter int TKEEP_WIDTH   = 8,
  parameter int LEN_W         = $clog2(MAX_MSG_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
  input  logic [LEN_W-1:0]           msg_len,
  input  logic                       msg_valid,
  input  logic                       msg_error,
  output logic                       msg_ready,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [63:0]                m_tdata,
  output logic [TKEEP_WIDTH-1:0]     m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tuser,
  output logic                       msg_sent,
  output logic [15:0]                msg_count
);

  localparam int NUM_BEATS = (MAX_MSG_BYTES + 7) / 8;
  localparam int BUF_BITS  = NUM_BEATS * 64;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_MSG_BYTES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_n;

  logic [8*MAX_MSG_BYTES-1:0] data_q;
  logic [8*MAX_MSG_BYTES-1:0] src_data;
  logic [BUF_BITS-1:0]        src_pad;
  logic [LEN_W-1:0]           len_q, len_clamp, src_len;
  logic [LEN_W-1:0]           beat_q, beat_n;
  logic                       err_q, src_err;
  logic                       load, advance, finish;
  logic [63:0]                beat_data;
  logic [TKEEP_WIDTH-1:0]     beat_keep;
  logic                       beat_last;
  int                         rem;

  assign len_clamp = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
  assign msg_ready = (state == IDLE) & rst;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // In IDLE the next beat comes straight from the inputs, since the buffer is loaded on the same edge.
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    advance  = 1'b0;
    finish   = 1'b0;
    beat_n   = beat_q;
    src_data = data_q;
    src_len  = len_q;
    src_err  = err_q;
    case (state)
      IDLE: begin
        if (msg_valid && (len_clamp != '0)) begin
          load     = 1'b1;
          state_n  = SEND;
          beat_n   = '0;
          src_data = msg_data;
          src_len  = len_clamp;
          src_err  = msg_error;
        end
      end
      SEND: begin
        if (m_tvalid && m_tready) begin
          if (m_tlast) begin
            finish  = 1'b1;
            state_n = IDLE;
          end else begin
            advance = 1'b1;
            beat_n  = beat_q + LEN_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // rem is the count of message bytes from the start of beat_n onward; it sets both keep and last.
  always_comb begin
    src_pad                      = '0;
    src_pad[8*MAX_MSG_BYTES-1:0] = src_data;
    rem       = int'(src_len) - 8 * int'(beat_n);
    beat_data = 64'(src_pad >> (64 * int'(beat_n)));
    beat_keep = '0;
    beat_last = (rem <= 8);
    for (int b = 0; b < TKEEP_WIDTH; b++) begin
      if (b < rem) beat_keep[b] = 1'b1;
      else         beat_data[8*b +: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tkeep   <= '0;
      m_tlast   <= 1'b0;
      m_tuser   <= 1'b0;
      msg_sent  <= 1'b0;
      msg_count <= '0;
      data_q    <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      beat_q    <= '0;
    end else begin
      msg_sent <= finish;
      if (load) begin
        data_q <= msg_data;
        len_q  <= len_clamp;
        err_q  <= msg_error;
      end
      if (load || advance) begin
        m_tvalid <= 1'b1;
        m_tdata  <= beat_data;
        m_tkeep  <= beat_keep;
        m_tlast  <= beat_last;
        m_tuser  <= beat_last & src_err;
        beat_q   <= beat_n;
      end else if (finish) begin
        m_tvalid  <= 1'b0;
        m_tdata   <= '0;
        m_tkeep   <= '0;
        m_tlast   <= 1'b0;
        m_tuser   <= 1'b0;
        msg_count <= msg_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_msg_transmitter.sv
// Bench for msg_transmitter: directed scenarios plus random traffic, checked every cycle
// against a queue-of-beats reference model.
module tb_msg_transmitter;

  localparam int MAX   = 32;
  localparam int LEN_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [8*MAX-1:0] msg_data;
  logic [LEN_W-1:0] msg_len;
  logic             msg_valid, msg_error, msg_ready;
  logic             m_tvalid, m_tready, m_tlast, m_tuser;
  logic [63:0]      m_tdata;
  logic [7:0]       m_tkeep;
  logic             msg_sent;
  logic [15:0]      msg_count;

  always #5 clk = ~clk;

  msg_transmitter #(.MAX_MSG_BYTES(MAX), .TKEEP_WIDTH(8), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .msg_data(msg_data), .msg_len(msg_len),
    .msg_valid(msg_valid), .msg_error(msg_error), .msg_ready(msg_ready),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .msg_sent(msg_sent), .msg_count(msg_count)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  beat_t       exp_q[$];
  logic [7:0]  cur_bytes[MAX];
  logic [15:0] model_count = '0;
  logic        exp_sent = 1'b0;
  logic        after_reset = 1'b0;
  int          n_compared = 0;
  int          n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  // Expected beats are derived from the message bytes and length rules only.
  task automatic push_message(input int len, input logic err);
    int    l, nb;
    beat_t bt;
    l  = (len > MAX) ? MAX : len;
    nb = (l + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      bt.data = '0;
      for (int b = 0; b < 8; b++)
        if (8*k + b < l) bt.data[8*b +: 8] = cur_bytes[8*k + b];
      if (k < nb - 1 || (l % 8) == 0) bt.keep = 8'hFF;
      else                            bt.keep = 8'((1 << (l % 8)) - 1);
      bt.last = (k == nb - 1);
      bt.user = bt.last & err;
      exp_q.push_back(bt);
    end
  endtask

  task automatic applyStimulus(input logic v, input int len, input logic err,
                               input logic rdy, input logic r);
    beat_t head;
    logic  exp_ready;
    rst       = r;
    msg_valid = v;
    msg_len   = LEN_W'(len);
    msg_error = err;
    m_tready  = rdy;
    for (int i = 0; i < MAX; i++) msg_data[8*i +: 8] = cur_bytes[i];

    if (!r) begin
      exp_q.delete();
      model_count = '0;
      exp_sent    = 1'b0;
      after_reset = 1'b1;
    end else begin
      after_reset = 1'b0;
      exp_sent    = 1'b0;
      if (exp_q.size() > 0) begin
        if (rdy) begin
          head = exp_q.pop_front();
          if (head.last) begin
            exp_sent = 1'b1;
            model_count++;
          end
        end
      end else if (v) begin
        push_message(len, err);
      end
    end

    @(posedge clk);
    @(negedge clk);

    exp_ready = r & (exp_q.size() == 0);
    checkOutput("msg_ready", 64'(msg_ready), 64'(exp_ready));
    checkOutput("m_tvalid", 64'(m_tvalid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      checkOutput("m_tdata", m_tdata, head.data);
      checkOutput("m_tkeep", 64'(m_tkeep), 64'(head.keep));
      checkOutput("m_tlast", 64'(m_tlast), 64'(head.last));
      checkOutput("m_tuser", 64'(m_tuser), 64'(head.user));
    end else if (after_reset) begin
      checkOutput("rst_tdata", m_tdata, 64'h0);
      checkOutput("rst_tkeep", 64'(m_tkeep), 64'h0);
      checkOutput("rst_tlast", 64'(m_tlast), 64'h0);
      checkOutput("rst_tuser", 64'(m_tuser), 64'h0);
    end
    checkOutput("msg_sent", 64'(msg_sent), 64'(exp_sent));
    checkOutput("msg_count", 64'(msg_count), 64'(model_count));
  endtask

  task automatic fill_seq();
    for (int i = 0; i < MAX; i++) cur_bytes[i] = 8'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < MAX; i++) cur_bytes[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    logic v, err, rdy, r;
    int   len;

    fill_seq();
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);

    $display("[TB] full 32-byte message");
    applyStimulus(1'b1, 32, 1'b0, 1'b1, 1'b1);
    checkOutput("beat0_const", m_tdata, 64'h0706050403020100);
    drain(6);

    $display("[TB] 13-byte partial message");
    applyStimulus(1'b1, 13, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
    checkOutput("beat1_const", m_tdata, 64'h0000000C0B0A0908);
    checkOutput("beat1_keep", 64'(m_tkeep), 64'h1F);
    drain(3);

    $display("[TB] backpressure on beat 1");
    fill_rand();
    applyStimulus(1'b1, 24, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    drain(4);

    $display("[TB] error flag, empty and oversize messages");
    applyStimulus(1'b1, 8, 1'b1, 1'b1, 1'b1);
    drain(2);
    applyStimulus(1'b1, 0, 1'b1, 1'b1, 1'b1);
    drain(2);
    fill_rand();
    applyStimulus(1'b1, 40, 1'b0, 1'b1, 1'b1);
    drain(6);

    $display("[TB] reset mid-message");
    fill_seq();
    applyStimulus(1'b1, 32, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    fill_rand();
    applyStimulus(1'b1, 20, 1'b1, 1'b1, 1'b1);
    drain(5);

    $display("[TB] back-to-back messages");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16, 1'b0, 1'b1, 1'b1);
    drain(5);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      fill_rand();
      r   = ($urandom_range(0, 149) != 0);
      v   = ($urandom_range(0, 2) == 0);
      len = $urandom_range(0, 40);
      err = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(v, len, err, rdy, r);
    end
    drain(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
